// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Single-clock parameterised FIFO with registered read data,
//               occupancy counter, full/empty and programmable almost-full /
//               almost-empty flags, and an overflow/underflow error flag.
//               Optional macro FIFO_ERR_STICKY_EN makes the error flag sticky
//               until reset; without it, error pulses for one cycle per
//               offending request.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   afull_thresh,
  input  logic [ADDR_WIDTH:0]   aempty_thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full_fifo,
  output logic                  empty_fifo,
  output logic                  almost_full_fifo,
  output logic                  almost_empty_fifo,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   cnt
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  error_q, error_d;

  // Request qualification
  logic push_ok;
  logic pop_ok;
  logic err_event;

  // Status flags derive from the registered count, so during reset (count
  // forced to zero) they read as an empty FIFO without any extra gating.
  assign full_fifo         = (cnt_q == DEPTH_CNT);
  assign empty_fifo        = (cnt_q == '0);
  assign almost_full_fifo  = (cnt_q >= afull_thresh);
  assign almost_empty_fifo = (cnt_q <= aempty_thresh);

  // A push against a full FIFO is still accepted when a pop frees a slot in
  // the same cycle; a pop against an empty FIFO is always refused, even when
  // a push arrives alongside it.
  assign push_ok   = push & (~full_fifo | pop);
  assign pop_ok    = pop & ~empty_fifo;
  assign err_event = (push & full_fifo & ~pop) | (pop & empty_fifo);

  // Next-state computation for pointers, count, read data and error flag
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    error_d     = error_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end

    if (pop_ok) begin
      // Reads the word before any same-cycle write lands, which matters
      // when full and both pointers address the same slot.
      data_out_d  = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
      valid_out_d = 1'b1;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   cnt_d = cnt_q - (ADDR_WIDTH + 1)'(1);
      default: cnt_d = cnt_q;
    endcase

`ifdef FIFO_ERR_STICKY_EN
    error_d = error_q | err_event;
`else
    error_d = err_event;
`endif
  end

  // Control and output registers, cleared immediately by the async reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
    end
  end

  // Storage array; contents are never cleared, stale words are unreachable
  // once the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign error     = error_q;
  assign cnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_param
// Description : Self-checking bench for fifo_sync_param. A queue-based model
//               tracks stored words, read data, valid and error; each test
//               task compares the DUT against it on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [AW:0]   afull_thresh;
  logic [AW:0]   aempty_thresh;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full_fifo;
  logic          empty_fifo;
  logic          almost_full_fifo;
  logic          almost_empty_fifo;
  logic          error;
  logic [AW:0]   cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_err;

  fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .push              (push),
    .pop               (pop),
    .data_in           (data_in),
    .afull_thresh      (afull_thresh),
    .aempty_thresh     (aempty_thresh),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .full_fifo         (full_fifo),
    .empty_fifo        (empty_fifo),
    .almost_full_fifo  (almost_full_fifo),
    .almost_empty_fifo (almost_empty_fifo),
    .error             (error),
    .cnt               (cnt)
  );

  always #5 clk = ~clk;

  // Applies one request at the falling edge, advances the model at the
  // rising edge and returns at the next falling edge ready for checking.
  task automatic cycle(input logic p, input logic r, input logic [DW-1:0] d);
    bit was_full;
    bit was_empty;
    bit ev;
    push    = p;
    pop     = r;
    data_in = d;
    @(posedge clk);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    ev        = (p && was_full && !r) || (r && was_empty);
    m_valid   = 1'b0;
    if (r && !was_empty) begin
      m_dout  = mq.pop_front();
      m_valid = 1'b1;
    end
    if (p && (!was_full || r)) mq.push_back(d);
    m_err = STICKY ? (m_err | ev) : ev;
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b0;
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    data_in       = '0;
    afull_thresh  = 4'd6;
    aempty_thresh = 4'd2;
    mq.delete();
    m_dout = '0; m_valid = 1'b0; m_err = 1'b0;
    #2;
    vectors++;
    if ({cnt, empty_fifo, full_fifo, valid_out, error, data_out} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0}) begin
      miscompares++;
      $display("FAIL reset_state: cnt=%0d empty=%b full=%b valid=%b err=%b dout=%h, expected 0 1 0 0 0 000",
               cnt, empty_fifo, full_fifo, valid_out, error, data_out);
    end
    vectors++;
    if ({almost_empty_fifo, almost_full_fifo} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_flags: ae=%b af=%b, expected 1 0", almost_empty_fifo, almost_full_fifo);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i));
    vectors++;
    if (full_fifo !== 1'b1 || cnt !== 4'd8) begin
      miscompares++;
      $display("FAIL fill_full: full=%b cnt=%0d, expected 1 8", full_fifo, cnt);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      vectors++;
      if (valid_out !== 1'b1 || data_out !== DW'(i) || data_out !== m_dout) begin
        miscompares++;
        $display("FAIL drain_word%0d: valid=%b dout=%h, expected 1 %h", i, valid_out, data_out, DW'(i));
      end
    end
    cycle(1'b0, 1'b0, '0);
    vectors++;
    if (empty_fifo !== 1'b1 || valid_out !== 1'b0 || data_out !== 10'h008) begin
      miscompares++;
      $display("FAIL drain_empty: empty=%b valid=%b dout=%h, expected 1 0 008", empty_fifo, valid_out, data_out);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'($urandom_range(0, 10'h3FE)));
    cycle(1'b1, 1'b0, 10'h3FF);
    vectors++;
    if (error !== 1'b1 || cnt !== 4'd8) begin
      miscompares++;
      $display("FAIL overflow_err: err=%b cnt=%0d, expected 1 8", error, cnt);
    end
    cycle(1'b0, 1'b0, '0);
    vectors++;
    if (error !== m_err) begin
      miscompares++;
      $display("FAIL overflow_err_after: err=%b, expected %b", error, m_err);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      vectors++;
      if (data_out === 10'h3FF || data_out !== m_dout || valid_out !== 1'b1) begin
        miscompares++;
        $display("FAIL overflow_drain%0d: dout=%h valid=%b, expected %h 1", i, data_out, valid_out, m_dout);
      end
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, DW'($urandom));
      vectors++;
      if (cnt !== 4'd8 || error !== 1'b0 || valid_out !== 1'b1 || data_out !== m_dout) begin
        miscompares++;
        $display("FAIL full_pp%0d: cnt=%0d err=%b valid=%b dout=%h, expected 8 0 1 %h",
                 i, cnt, error, valid_out, data_out, m_dout);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      vectors++;
      if (data_out !== m_dout || cnt !== 4'(mq.size())) begin
        miscompares++;
        $display("FAIL full_pp_drain%0d: dout=%h cnt=%0d, expected %h %0d", i, data_out, cnt, m_dout, mq.size());
      end
    end
  endtask

  task automatic test_thresholds();
    apply_reset();
    afull_thresh  = 4'd6;
    aempty_thresh = 4'd2;
    for (int k = 0; k <= DEPTH; k++) begin
      #1;
      vectors++;
      if (cnt !== 4'(k) || almost_empty_fifo !== (k <= 2) || almost_full_fifo !== (k >= 6)) begin
        miscompares++;
        $display("FAIL thresh_cnt%0d: cnt=%0d ae=%b af=%b, expected %0d %b %b",
                 k, cnt, almost_empty_fifo, almost_full_fifo, k, (k <= 2), (k >= 6));
      end
      if (k < DEPTH) cycle(1'b1, 1'b0, DW'($urandom));
    end
    // Thresholds beyond the depth, applied without a clock edge
    afull_thresh  = 4'd9;
    aempty_thresh = 4'd8;
    #1;
    vectors++;
    if (almost_full_fifo !== 1'b0 || almost_empty_fifo !== 1'b1) begin
      miscompares++;
      $display("FAIL thresh_beyond: af=%b ae=%b, expected 0 1", almost_full_fifo, almost_empty_fifo);
    end
    afull_thresh  = 4'd8;
    aempty_thresh = 4'd7;
    #1;
    vectors++;
    if (almost_full_fifo !== 1'b1 || almost_empty_fifo !== 1'b0) begin
      miscompares++;
      $display("FAIL thresh_edge: af=%b ae=%b, expected 1 0", almost_full_fifo, almost_empty_fifo);
    end
    afull_thresh  = 4'd6;
    aempty_thresh = 4'd2;
  endtask

  task automatic test_underflow_and_reset();
    apply_reset();
    cycle(1'b0, 1'b1, '0);
    vectors++;
    if (error !== 1'b1 || valid_out !== 1'b0 || cnt !== 4'd0 || data_out !== 10'd0) begin
      miscompares++;
      $display("FAIL underflow: err=%b valid=%b cnt=%0d dout=%h, expected 1 0 0 000", error, valid_out, cnt, data_out);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, '0);
      vectors++;
      if (error !== STICKY) begin
        miscompares++;
        $display("FAIL underflow_idle%0d: err=%b, expected %b", i, error, STICKY);
      end
    end
    cycle(1'b1, 1'b1, 10'h155);
    vectors++;
    if (cnt !== 4'd1 || valid_out !== 1'b0 || error !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_pp: cnt=%0d valid=%b err=%b, expected 1 0 1", cnt, valid_out, error);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'($urandom));
    cycle(1'b1, 1'b1, DW'($urandom));
    vectors++;
    if (cnt !== 4'd5 || valid_out !== 1'b1 || data_out !== 10'h155) begin
      miscompares++;
      $display("FAIL midfill: cnt=%0d valid=%b dout=%h, expected 5 1 155", cnt, valid_out, data_out);
    end
    // Asynchronous reset away from any clock edge
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (cnt !== 4'd0 || error !== 1'b0 || valid_out !== 1'b0 || empty_fifo !== 1'b1 || data_out !== 10'd0) begin
      miscompares++;
      $display("FAIL async_reset: cnt=%0d err=%b valid=%b empty=%b dout=%h, expected 0 0 0 1 000",
               cnt, error, valid_out, empty_fifo, data_out);
    end
    mq.delete();
    m_dout = '0; m_valid = 1'b0; m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 10'h2AA);
    cycle(1'b0, 1'b1, '0);
    vectors++;
    if (cnt !== 4'd0 || valid_out !== 1'b1 || data_out !== 10'h2AA) begin
      miscompares++;
      $display("FAIL post_reset: cnt=%0d valid=%b dout=%h, expected 0 1 2aa", cnt, valid_out, data_out);
    end
  endtask

  task automatic test_random();
    bit p;
    bit r;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if ((i % 50) == 0) begin
        afull_thresh  = 4'($urandom_range(0, 15));
        aempty_thresh = 4'($urandom_range(0, 15));
      end
      // Alternate phases biased toward filling and toward draining
      if (((i / 40) % 2) == 0) begin
        p = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 3);
      end else begin
        p = ($urandom_range(0, 9) < 3);
        r = ($urandom_range(0, 9) < 7);
      end
      cycle(p, r, DW'($urandom));
      vectors++;
      if (cnt !== 4'(mq.size()) || full_fifo !== (mq.size() == DEPTH) || empty_fifo !== (mq.size() == 0) ||
          almost_full_fifo !== (mq.size() >= int'(afull_thresh)) ||
          almost_empty_fifo !== (mq.size() <= int'(aempty_thresh)) ||
          valid_out !== m_valid || data_out !== m_dout || error !== m_err) begin
        miscompares++;
        $display("FAIL random%0d: cnt=%0d f=%b e=%b af=%b ae=%b v=%b d=%h err=%b, expected cnt=%0d v=%b d=%h err=%b",
                 i, cnt, full_fifo, empty_fifo, almost_full_fifo, almost_empty_fifo, valid_out, data_out, error,
                 mq.size(), m_valid, m_dout, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_thresholds();
    test_underflow_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
